// File: rtl/vote_logger.sv
// rtl/vote_logger.sv - one-vote-per-lockout tally keeper with saturating per-candidate and total counts
module vote_logger #(
    parameter int NUM_CAND    = 4,
    parameter int SEL_W       = 2,
    parameter int CNT_W       = 8,
    parameter int TOT_W       = 10,
    parameter int LOCKOUT_CYC = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic [NUM_CAND-1:0] cand_valid,
    input  logic [SEL_W-1:0]    result_sel,
    output logic                vote_ack,
    output logic                vote_reject,
    output logic                busy,
    output logic [CNT_W-1:0]    vote_count,
    output logic [TOT_W-1:0]    total_votes
);

    localparam int TMR_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCKOUT_CYC - 1);

    typedef enum logic [1:0] {
        VOTING  = 2'd0,
        LOCKOUT = 2'd1,
        RESULT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   tally_q [NUM_CAND];
    logic [CNT_W-1:0]   tally_d [NUM_CAND];
    logic [TOT_W-1:0]   total_q, total_d;
    logic               ack_q, ack_d;
    logic               rej_q, rej_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               any_press;
    logic               single_press;
    logic               target_full;
    logic [CNT_W-1:0]   sel_tally;

    always_comb begin
        any_press    = |cand_valid;
        // clearing the lowest set bit leaves zero only for a one-hot press
        single_press = any_press && ((cand_valid & (cand_valid - NUM_CAND'(1))) == '0);
        target_full  = 1'b0;
        sel_tally    = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cand_valid[i] && (tally_q[i] == '1)) begin
                target_full = 1'b1;
            end
            if (result_sel == SEL_W'(i)) begin
                sel_tally = tally_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tally_d = tally_q;
        total_d = total_q;
        ack_d   = 1'b0;
        rej_d   = 1'b0;

        case (state_q)
            VOTING: begin
                if (mode) begin
                    state_d = RESULT;
                end else if (any_press) begin
                    if (single_press && !target_full) begin
                        for (int i = 0; i < NUM_CAND; i++) begin
                            if (cand_valid[i]) begin
                                tally_d[i] = tally_q[i] + CNT_W'(1);
                            end
                        end
                        total_d = (total_q == '1) ? total_q : total_q + TOT_W'(1);
                        ack_d   = 1'b1;
                        timer_d = TMR_LOAD;
                        state_d = LOCKOUT;
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = mode ? RESULT : VOTING;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            RESULT: begin
                if (!mode) begin
                    state_d = VOTING;
                end
            end
            default: begin
                state_d = VOTING;
            end
        endcase

        // keyed off the next state so the display clears on the edge that leaves RESULT
        count_d = (state_d == RESULT) ? sel_tally : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= VOTING;
            timer_q <= '0;
            total_q <= '0;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
            count_q <= '0;
            for (int i = 0; i < NUM_CAND; i++) begin
                tally_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            total_q <= total_d;
            ack_q   <= ack_d;
            rej_q   <= rej_d;
            count_q <= count_d;
            for (int i = 0; i < NUM_CAND; i++) begin
                tally_q[i] <= tally_d[i];
            end
        end
    end

    assign vote_ack    = ack_q;
    assign vote_reject = rej_q;
    assign busy        = (state_q == LOCKOUT);
    assign vote_count  = count_q;
    assign total_votes = total_q;

endmodule
